// File: rtl/cep_irq_ctrl_axi4lite_pkg.sv
// Shared definitions for the CEP interrupt controller: register offsets,
// response codes, source mode and FSM state encodings, default version.
package cep_irq_ctrl_pkg;

    // Register indices taken from addr[4:2]
    localparam logic [2:0] REG_PENDING = 3'd0;
    localparam logic [2:0] REG_ENABLE  = 3'd1;
    localparam logic [2:0] REG_MODE    = 3'd2;
    localparam logic [2:0] REG_RAW     = 3'd3;
    localparam logic [2:0] REG_ACTIVE  = 3'd4;
    localparam logic [2:0] REG_ID      = 3'd5;
    localparam logic [2:0] REG_INFO    = 3'd6;
    localparam logic [2:0] REG_SWSET   = 3'd7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [7:0] DEFAULT_VERSION = 8'h01;

    typedef enum logic {
        IRQ_LEVEL = 1'b0,
        IRQ_EDGE  = 1'b1
    } irq_mode_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Lowest-index active source in [5:0], or bit 31 set when nothing is active
    function automatic logic [31:0] irq_id(input logic [31:0] active);
        irq_id = 32'h8000_0000;
        for (int i = 31; i >= 0; i--) begin
            if (active[i]) begin
                irq_id = {26'd0, i[5:0]};
            end
        end
    endfunction

endpackage

// File: rtl/cep_irq_ctrl_axi4lite_if.sv
// AXI4-Lite channel bundle between the crossbar (master) and the
// interrupt controller (slave).
interface cep_irq_ctrl_axi4lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/cep_irq_ctrl_axi4lite_sync_edge.sv
// Per-source synchroniser chain with rising-edge detect on the synchronised value.
module cep_irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic raw,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   raw_prev_q;

    // Shift the source through the chain and remember the previous RAW for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            raw_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= src;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            raw_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign raw  = sync_q[SYNC_STAGES-1];
    assign rise = raw & ~raw_prev_q;

endmodule

// File: rtl/cep_irq_ctrl_axi4lite.sv
// CEP interrupt controller with an AXI4-Lite register port.
// Optional feature macro: CEP_IRQ_CTRL_SWTRIG_EN adds the write-only SWSET
// register at 0x1C; without it 0x1C is unmapped.
// The crossbar is expected to deliver offsets, so any address bit above [4]
// makes the access unmapped.
module cep_irq_ctrl_axi4lite
    import cep_irq_ctrl_pkg::*;
#(
    parameter int         NUM_IRQ     = 32,
    parameter int         ADDR_W      = 32,
    parameter int         DATA_W      = 32,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] VERSION     = DEFAULT_VERSION
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cep_irq_ctrl_axi4lite_if.slave slave,
    input  logic [NUM_IRQ-1:0]   irq_src_i,
    output logic [NUM_IRQ-1:0]   pic_ints_o,
    output logic                 irq_o
);

    localparam logic [31:0] VALID_MASK = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << NUM_IRQ) - 32'd1);
    localparam logic [5:0]  NUM_FIELD  = NUM_IRQ[5:0];

    logic [31:0] raw, rise;
    logic [31:0] pending_q, enable_q, mode_q, pending_d, active;
    logic [31:0] w1c_mask, swset_mask;
    logic        enable_we, mode_we;
    logic [1:0]  wr_resp, rd_resp, bresp_q, rresp_q;
    logic [DATA_W-1:0] rd_data, rdata_q;
    logic        wr_in_window, rd_in_window;
    logic [2:0]  wr_idx, rd_idx;

    wr_state_e   w_state_q, w_state_d;
    rd_state_e   r_state_q, r_state_d;
    logic        w_fire, r_fire, aw_ready, b_valid, ar_ready, r_valid;

    logic        unused_bits;
    assign unused_bits = ^{slave.wstrb, slave.awaddr[1:0], slave.araddr[1:0]};

    for (genvar g = 0; g < 32; g++) begin : g_src
        if (g < NUM_IRQ) begin : g_used
            cep_irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
                .clk  (clk_i),
                .rst  (rst_i),
                .src  (irq_src_i[g]),
                .raw  (raw[g]),
                .rise (rise[g])
            );
        end else begin : g_absent
            assign raw[g]  = 1'b0;
            assign rise[g] = 1'b0;
        end
    end

    assign active       = pending_q & enable_q;
    assign wr_idx       = slave.awaddr[4:2];
    assign rd_idx       = slave.araddr[4:2];
    assign wr_in_window = (slave.awaddr[ADDR_W-1:5] == '0);
    assign rd_in_window = (slave.araddr[ADDR_W-1:5] == '0);

    // Write channel state register
    always_ff @(posedge clk_i) begin
        if (rst_i) w_state_q <= W_IDLE;
        else       w_state_q <= w_state_d;
    end

    // Write FSM: accept AW and W together in idle, then hold the response until bready
    always_comb begin
        w_state_d = w_state_q;
        aw_ready  = 1'b0;
        b_valid   = 1'b0;
        w_fire    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_ready = slave.awvalid & slave.wvalid;
                w_fire   = aw_ready;
                if (w_fire) w_state_d = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (slave.bready) w_state_d = W_IDLE;
            end
        endcase
    end

    // Read channel state register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state_q <= R_IDLE;
        else       r_state_q <= r_state_d;
    end

    // Read FSM: take an address in idle, then hold the captured data until rready
    always_comb begin
        r_state_d = r_state_q;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_fire    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_ready = 1'b1;
                r_fire   = slave.arvalid;
                if (r_fire) r_state_d = R_DATA;
            end
            R_DATA: begin
                r_valid = 1'b1;
                if (slave.rready) r_state_d = R_IDLE;
            end
        endcase
    end

    // Write decode: turn an accepted write into per-register strobes and a response
    always_comb begin
        w1c_mask   = '0;
        swset_mask = '0;
        enable_we  = 1'b0;
        mode_we    = 1'b0;
        wr_resp    = RESP_SLVERR;
        if (wr_in_window) begin
            case (wr_idx)
                REG_PENDING: begin
                    w1c_mask = w_fire ? (slave.wdata[31:0] & VALID_MASK) : '0;
                    wr_resp  = RESP_OKAY;
                end
                REG_ENABLE: begin
                    enable_we = w_fire;
                    wr_resp   = RESP_OKAY;
                end
                REG_MODE: begin
                    mode_we = w_fire;
                    wr_resp = RESP_OKAY;
                end
`ifdef CEP_IRQ_CTRL_SWTRIG_EN
                REG_SWSET: begin
                    swset_mask = w_fire ? (slave.wdata[31:0] & VALID_MASK) : '0;
                    wr_resp    = RESP_OKAY;
                end
`endif
                default: wr_resp = RESP_SLVERR;
            endcase
        end
    end

    // Next PENDING: edge bits latch rises and software sets (both beat a clear), level bits track RAW
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < 32; i++) begin
            if (irq_mode_e'(mode_q[i]) == IRQ_EDGE) begin
                pending_d[i] = (pending_q[i] & ~w1c_mask[i]) | rise[i] | swset_mask[i];
            end else begin
                pending_d[i] = raw[i];
            end
        end
        pending_d = pending_d & VALID_MASK;
    end

    // Read decode: value and response sampled from the pre-write register state
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        if (rd_in_window) begin
            rd_resp = RESP_OKAY;
            case (rd_idx)
                REG_PENDING: rd_data = pending_q;
                REG_ENABLE:  rd_data = enable_q;
                REG_MODE:    rd_data = mode_q;
                REG_RAW:     rd_data = raw;
                REG_ACTIVE:  rd_data = active;
                REG_ID:      rd_data = irq_id(active);
                REG_INFO:    rd_data = {VERSION, 18'd0, NUM_FIELD};
`ifdef CEP_IRQ_CTRL_SWTRIG_EN
                REG_SWSET:   rd_data = '0;
`endif
                default:     rd_resp = RESP_SLVERR;
            endcase
        end
    end

    // Register file, output registers and captured bus responses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            pic_ints_o <= '0;
            irq_o      <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            pending_q  <= pending_d;
            if (enable_we) enable_q <= slave.wdata[31:0] & VALID_MASK;
            if (mode_we)   mode_q   <= slave.wdata[31:0] & VALID_MASK;
            pic_ints_o <= active[NUM_IRQ-1:0];
            irq_o      <= |active;
            if (w_fire) bresp_q <= wr_resp;
            if (r_fire) begin
                rdata_q <= rd_data;
                rresp_q <= rd_resp;
            end
        end
    end

    assign slave.awready = aw_ready;
    assign slave.wready  = aw_ready;
    assign slave.bvalid  = b_valid;
    assign slave.bresp   = bresp_q;
    assign slave.arready = ar_ready;
    assign slave.rvalid  = r_valid;
    assign slave.rdata   = rdata_q;
    assign slave.rresp   = rresp_q;

endmodule
